led_pattern_sequencer: RTL and testbench

Run-time controller for the board's 8-LED bar. It turns single-cycle button events (start/pause, stop, mode, speed) into a sequenced LED pattern with a selectable step rate. It sits between the button conditioning logic and the `led` pins, and generalises the fixed single-direction flowing-light behaviour into a small scheduler with four pattern modes and four speeds.

---
 rtl/led_seq_pkg.sv | 31 +++
 rtl/led_pattern_sequencer_tick.sv | 32 +++
 rtl/led_pattern_sequencer.sv | 144 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings and pattern helpers for the LED bar sequencer.
// Pure definitions: no state, no latency, no flow control.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [7:0] LED_OFF = 8'h00;

    function automatic logic [7:0] init_pattern(input mode_t m);
        return (m == MODE_ROT_R) ? 8'h80 : 8'h01;
    endfunction

    // FILL holds a contiguous run of ones from bit 0; every other mode is one-hot.
    function automatic logic is_legal(input mode_t m, input logic [7:0] v);
        if (m == MODE_FILL)
            return (v != 8'h00) && ((v & (v + 8'h01)) == 8'h00);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick.sv
// Step-rate counter: pulses tick once every TICK_BASE << (3 - speed) enabled cycles.
// Latency: tick is a decode of the registered count; no backpressure (en/clr always accepted).
module led_tick_gen #(
    parameter int unsigned TICK_BASE = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [31:0] cnt;
    logic [31:0] period;

    assign period = 32'(TICK_BASE) << (2'd3 - speed);

    // >= keeps the counter from running away if it ever sits beyond the period.
    assign tick = en && (cnt >= period - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 32'd0;
        end else if (clr) begin
            cnt <= 32'd0;
        end else if (en) begin
            cnt <= tick ? 32'd0 : cnt + 32'd1;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Button-driven LED bar sequencer: four pattern modes, four step rates, run/pause/stop.
// Latency: every event shows on the outputs one edge later; no backpressure, events always accepted.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_BASE = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_mode,
    input  logic       btn_speed,
    output logic [7:0] led,
    output logic       busy,
    output logic [1:0] mode,
    output logic [1:0] speed
);

    state_t      state, state_nxt;
    mode_t       mode_r, mode_nxt;
    logic [1:0]  speed_r, speed_nxt;
    logic [7:0]  led_r, led_nxt;
    logic        dir_right, dir_nxt;

    logic        tick;
    logic        tick_en;
    logic        tick_clr;
    logic        reload;

    logic [7:0]  step_led;
    logic        step_dir;
    logic        bounce_left;

    led_tick_gen #(
        .TICK_BASE(TICK_BASE)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (tick_en),
        .clr   (tick_clr),
        .speed (speed_r),
        .tick  (tick)
    );

    assign tick_en = (state == RUN);

    // Next pattern value for one step; anything unreachable restarts the mode.
    always_comb begin
        step_led    = init_pattern(mode_r);
        step_dir    = 1'b0;
        bounce_left = 1'b0;
        if (is_legal(mode_r, led_r)) begin
            case (mode_r)
                MODE_ROT_L: step_led = {led_r[6:0], led_r[7]};
                MODE_ROT_R: step_led = {led_r[0], led_r[7:1]};
                MODE_BOUNCE: begin
                    bounce_left = dir_right ? (led_r == 8'h01) : (led_r != 8'h80);
                    step_led    = bounce_left ? {led_r[6:0], 1'b0} : {1'b0, led_r[7:1]};
                    if (step_led == 8'h80)
                        step_dir = 1'b1;
                    else if (step_led == 8'h01)
                        step_dir = 1'b0;
                    else
                        step_dir = !bounce_left;
                end
                MODE_FILL: step_led = (led_r == 8'hFF) ? 8'h01 : {led_r[6:0], 1'b1};
                default: step_led = init_pattern(mode_r);
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        led_nxt   = led_r;
        dir_nxt   = dir_right;
        mode_nxt  = btn_mode ? mode_t'(mode_r + 2'd1) : mode_r;
        speed_nxt = speed_r + {1'b0, btn_speed};
        tick_clr  = btn_speed;
        reload    = 1'b0;

        case (state)
            IDLE: begin
                led_nxt = LED_OFF;
                dir_nxt = 1'b0;
                if (btn_start && !btn_stop) begin
                    state_nxt = RUN;
                    reload    = 1'b1;
                end
            end
            RUN, PAUSE: begin
                if (btn_stop) begin
                    state_nxt = IDLE;
                    led_nxt   = LED_OFF;
                    dir_nxt   = 1'b0;
                    tick_clr  = 1'b1;
                end else begin
                    if (btn_start)
                        state_nxt = (state == RUN) ? PAUSE : RUN;
                    // A mode change wins over a step landing in the same cycle.
                    if (btn_mode) begin
                        reload = 1'b1;
                    end else if ((state == RUN) && tick && !btn_speed) begin
                        led_nxt = step_led;
                        dir_nxt = step_dir;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                led_nxt   = LED_OFF;
                dir_nxt   = 1'b0;
            end
        endcase

        if (reload) begin
            led_nxt  = init_pattern(mode_nxt);
            dir_nxt  = 1'b0;
            tick_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_r    <= MODE_ROT_L;
            speed_r   <= 2'd0;
            led_r     <= LED_OFF;
            dir_right <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_r    <= mode_nxt;
            speed_r   <= speed_nxt;
            led_r     <= led_nxt;
            dir_right <= dir_nxt;
        end
    end

    assign led   = led_r;
    assign busy  = (state != IDLE);
    assign mode  = mode_r;
    assign speed = speed_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboarded bench for led_pattern_sequencer at TICK_BASE = 2 (P = 16/8/4/2).
module tb_led_pattern_sequencer;

    localparam int unsigned TICK_BASE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_speed = 1'b0;
    logic [7:0] led;
    logic       busy;
    logic [1:0] mode;
    logic [1:0] speed;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .TICK_BASE(TICK_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_mode  (btn_mode),
        .btn_speed (btn_speed),
        .led       (led),
        .busy      (busy),
        .mode      (mode),
        .speed     (speed)
    );

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;

    logic       e_busy  = 1'b0;
    logic [1:0] e_mode  = 2'd0;
    logic [1:0] e_speed = 2'd0;

    logic [7:0] rotl_tbl   [9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_tbl [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_tbl   [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

    // Observed/expected packed as {busy, mode, speed, led}.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h ({busy,mode,speed,led})", tag, obs, exp);
        end
    endtask

    // One clock: drive events, queue the expected outputs, then compare after the edge.
    task automatic apply(input logic r, input logic s, input logic p, input logic m,
                         input logic sp, input string tag, input logic [7:0] e_led);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst       = r;
        btn_start = s;
        btn_stop  = p;
        btn_mode  = m;
        btn_speed = sp;
        if (r) begin
            e_busy  = 1'b0;
            e_mode  = 2'd0;
            e_speed = 2'd0;
        end else begin
            if (m)  e_mode  = e_mode + 2'd1;
            if (sp) e_speed = e_speed + 2'd1;
        end
        e.tag = tag;
        e.v   = {e_busy, e_mode, e_speed, e_led};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check(got.tag, {19'd0, busy, mode, speed, led}, {19'd0, got.v});
        end
    endtask

    task automatic hold(input int n, input string tag, input logic [7:0] v);
        repeat (n) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag, v);
    endtask

    task automatic step(input string tag, input logic [7:0] cur, input logic [7:0] nxt, input int p);
        hold(p - 1, {tag, "_hold"}, cur);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_step"}, nxt);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "reset", 8'h00);

        // ROT_L at speed 0: first step 16 cycles after start, full wrap back to 01.
        e_busy = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start", 8'h01);
        for (int j = 1; j < 9; j++) step("rotl", rotl_tbl[j-1], rotl_tbl[j], 16);

        // Pause three cycles after a tick; resume keeps the remaining 13 cycles.
        hold(2, "pre_pause", 8'h01);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "pause", 8'h01);
        hold(20, "paused", 8'h01);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "resume", 8'h01);
        hold(12, "resume_wait", 8'h01);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "resume_step", 8'h02);

        // Mode change landing on a tick with led = 04 reloads ROT_R.
        step("rotl2", 8'h02, 8'h04, 16);
        hold(15, "pre_mode", 8'h04);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mode_on_tick", 8'h80);
        step("rotr", 8'h80, 8'h40, 16);

        e_busy = 1'b0;
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "stop", 8'h00);

        // BOUNCE at speed 3 configured while idle.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset2", 8'h00);
        repeat (2) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "idle_mode", 8'h00);
        repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_speed", 8'h00);
        e_busy = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "bounce_start", 8'h01);
        for (int j = 1; j < 16; j++) step("bounce", bounce_tbl[j-1], bounce_tbl[j], 2);

        // FILL reload from RUN, then stop beats start.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fill_reload", 8'h01);
        for (int j = 1; j < 9; j++) step("fill", fill_tbl[j-1], fill_tbl[j], 2);
        e_busy = 1'b0;
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "stop_start", 8'h00);

        // Start with mode in IDLE enters the new mode; a speed change restarts the period.
        e_busy = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "start_mode", 8'h01);
        step("rotl_fast", 8'h01, 8'h02, 2);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "speed_chg", 8'h02);
        step("rotl_slow", 8'h02, 8'h04, 16);

        hold(5, "pre_rst", 8'h04);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rst_in_run", 8'h00);

        @(negedge clk);
        rst       = 1'b0;
        btn_speed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
